program_loader: RTL

//   Upstream stage of the accumulator CPU. Accepts a stream of instruction words over a

---
 rtl/loader_pkg.sv | 19 +
 rtl/loader_xor_acc.sv | 24 ++
 rtl/program_loader.sv | 130 +++++++++++++
 3 files changed

// File: rtl/loader_pkg.sv
// Shared types for the program loader: FSM state encoding and counter sizing.
`timescale 1ns/1ps
package loader_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    FILL  = 3'd2,
    CHECK = 3'd3,
    DONE  = 3'd4,
    ERROR = 3'd5
  } state_t;

  // One extra bit so the slot counter can reach PROGRAM_SIZE without wrapping.
  function automatic int LOADER_CNT_W(input int program_size);
    return $clog2(program_size) + 1;
  endfunction

endpackage

// File: rtl/loader_xor_acc.sv
// Running XOR of accepted stream words; clr wins over en.
`timescale 1ns/1ps
module loader_xor_acc #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] din,
  output logic [W-1:0] acc
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
    end else if (clr) begin
      acc <= '0;
    end else if (en) begin
      acc <= acc ^ din;
    end
  end

endmodule

// File: rtl/program_loader.sv
// Streams instruction words into program memory, pads unused slots, then releases the CPU.
// Optional checksum stage enabled by defining LOADER_CHECKSUM_EN.
`timescale 1ns/1ps
module program_loader
  import loader_pkg::*;
#(
  parameter int                    INSTR_SIZE   = 16,
  parameter int                    ADDR_SIZE    = 5,
  parameter int                    PROGRAM_SIZE = 16,
  parameter logic [INSTR_SIZE-1:0] FILL_WORD    = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [INSTR_SIZE-1:0] in_instr,
  input  logic                  in_last,
  output logic                  mem_we,
  output logic [ADDR_SIZE-1:0]  mem_addr,
  output logic [INSTR_SIZE-1:0] mem_wdata,
  output logic                  busy,
  output logic                  cpu_run,
  output logic                  error,
  output state_t                state_dbg
);

  localparam int               CNT_W     = LOADER_CNT_W(PROGRAM_SIZE);
  localparam logic [CNT_W-1:0] LAST_SLOT = CNT_W'(PROGRAM_SIZE - 1);

`ifdef LOADER_CHECKSUM_EN
  localparam state_t END_STATE = CHECK;
`else
  localparam state_t END_STATE = DONE;
`endif

  state_t           state, state_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic             accept;
  logic             start_ok;
  logic             load_accept;

  // Handshake: a word transfers on a rising edge where in_valid and in_ready are both 1;
  // in_ready depends only on state, never on in_valid.
  assign in_ready    = (state == LOAD) || (state == CHECK);
  assign accept      = in_valid && in_ready;
  assign busy        = (state == LOAD) || (state == FILL) || (state == CHECK);
  assign start_ok    = start && !busy;
  assign load_accept = (state == LOAD) && accept;
  assign state_dbg   = state;

`ifdef LOADER_CHECKSUM_EN
  logic [INSTR_SIZE-1:0] csum;
  logic                  error_q;

  loader_xor_acc #(.W(INSTR_SIZE)) u_xor_acc (
    .clk (clk),
    .rst (rst),
    .clr (start_ok),
    .en  (load_accept),
    .din (in_instr),
    .acc (csum)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) error_q <= 1'b0;
    else     error_q <= (state_d == ERROR);
  end

  assign error = error_q;
`else
  assign error = 1'b0;
`endif

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    case (state)
      IDLE, DONE, ERROR: begin
        if (start) begin
          state_d = LOAD;
          cnt_d   = '0;
        end
      end
      LOAD: begin
        if (accept) begin
          cnt_d = cnt + 1'b1;
          if (in_last || cnt == LAST_SLOT) begin
            state_d = (cnt != LAST_SLOT) ? FILL : END_STATE;
          end
        end
      end
      FILL: begin
        cnt_d = cnt + 1'b1;
        if (cnt == LAST_SLOT) state_d = END_STATE;
      end
`ifdef LOADER_CHECKSUM_EN
      CHECK: begin
        if (accept) state_d = (in_instr == csum) ? DONE : ERROR;
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      cpu_run   <= 1'b0;
    end else begin
      state   <= state_d;
      cnt     <= cnt_d;
      mem_we  <= load_accept || (state == FILL);
      // Run asserts one cycle after DONE is entered, so the last write lands first.
      cpu_run <= (state == DONE) && (state_d == DONE);
      if (load_accept) begin
        mem_addr  <= ADDR_SIZE'(cnt);
        mem_wdata <= in_instr;
      end else if (state == FILL) begin
        mem_addr  <= ADDR_SIZE'(cnt);
        mem_wdata <= FILL_WORD;
      end
    end
  end

endmodule
